// File: rtl/naive_bus_arb_pkg.sv
// Shared types and helpers for naive_bus arbiters: master index type and
// a wrap-around increment for round-robin pointers.
package naive_bus_arb_pkg;

  localparam int NB_ARB_MAX_MASTERS = 8;

  typedef logic [2:0] idx_t;

  // Wraps explicitly at n-1 so non-power-of-two master counts stay in range.
  function automatic idx_t nb_wrap_inc(idx_t idx, int n);
    if (int'(idx) >= n - 1)
      return '0;
    else
      return idx + 3'd1;
  endfunction

endpackage

// File: rtl/nb_rr_pick.sv
// Combinational picker: first asserted request at or after ptr, wrapping
// modulo N. Reusable by any rotating-priority arbiter.
module nb_rr_pick
  import naive_bus_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  idx_t         ptr,
  output logic         found,
  output idx_t         idx
);

  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = idx_t'(j);
      end
    end
  end

endmodule

// File: rtl/naive_bus_arbiter.sv
// Shares one naive_bus slave port between N_MASTERS requesters.
// NB_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority (index 0 highest).
module naive_bus_arbiter
  import naive_bus_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_MASTERS-1:0]      m_rd_req,
  input  logic [N_MASTERS*AW-1:0]   m_rd_addr,
  output logic [N_MASTERS-1:0]      m_rd_gnt,
  output logic [N_MASTERS*DW-1:0]   m_rd_data,
  input  logic [N_MASTERS-1:0]      m_wr_req,
  input  logic [N_MASTERS*AW-1:0]   m_wr_addr,
  input  logic [N_MASTERS*DW-1:0]   m_wr_data,
  input  logic [N_MASTERS*DW/8-1:0] m_wr_be,
  output logic [N_MASTERS-1:0]      m_wr_gnt,
  output logic                      s_rd_req,
  output logic [AW-1:0]             s_rd_addr,
  input  logic                      s_rd_gnt,
  input  logic [DW-1:0]             s_rd_data,
  output logic                      s_wr_req,
  output logic [AW-1:0]             s_wr_addr,
  output logic [DW-1:0]             s_wr_data,
  output logic [DW/8-1:0]           s_wr_be,
  input  logic                      s_wr_gnt
);

  localparam int BW = DW / 8;

  logic [N_MASTERS-1:0] cand;
  idx_t                 ptr;
  logic                 found;
  idx_t                 pick_idx;
  logic                 lock_vld;
  idx_t                 lock_idx;
  logic                 rd_own_vld;
  idx_t                 rd_own_idx;
  idx_t                 owner;
  logic                 rd_fire;
  logic                 any_gnt;
  logic                 fwd;

  assign cand = m_rd_req | m_wr_req;

`ifdef NB_ARB_ROUND_ROBIN_EN
  idx_t rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (any_gnt)
      rr_ptr <= nb_wrap_inc(owner, N_MASTERS);
  end

  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  nb_rr_pick #(.N(N_MASTERS)) u_pick (
    .req   (cand),
    .ptr   (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  assign owner = lock_vld ? lock_idx : pick_idx;

  // A locked owner that dropped its request forwards nothing; the lock then clears.
  always_comb begin
    logic own_rd;
    logic own_wr;
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    s_rd_req  = 1'b0;
    s_wr_req  = 1'b0;
    s_rd_addr = '0;
    s_wr_addr = '0;
    s_wr_data = '0;
    s_wr_be   = '0;
    m_rd_gnt  = '0;
    m_wr_gnt  = '0;
    if (|cand) begin
      own_rd    = m_rd_req[owner];
      own_wr    = m_wr_req[owner];
      s_rd_req  = own_rd;
      s_wr_req  = own_wr & ~own_rd;
      s_rd_addr = m_rd_addr[int'(owner)*AW +: AW];
      s_wr_addr = m_wr_addr[int'(owner)*AW +: AW];
      s_wr_data = m_wr_data[int'(owner)*DW +: DW];
      s_wr_be   = m_wr_be[int'(owner)*BW +: BW];
      m_rd_gnt[owner] = s_rd_req & s_rd_gnt;
      m_wr_gnt[owner] = s_wr_req & s_wr_gnt;
    end
  end

  assign rd_fire = s_rd_req & s_rd_gnt;
  assign any_gnt = rd_fire | (s_wr_req & s_wr_gnt);
  assign fwd     = s_rd_req | s_wr_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld   <= 1'b0;
      lock_idx   <= '0;
      rd_own_vld <= 1'b0;
      rd_own_idx <= '0;
    end else begin
      if (any_gnt) begin
        lock_vld <= 1'b0;
      end else if (fwd) begin
        lock_vld <= 1'b1;
        lock_idx <= owner;
      end else begin
        lock_vld <= 1'b0;
      end
      rd_own_vld <= rd_fire;
      if (rd_fire) rd_own_idx <= owner;
    end
  end

  always_comb begin
    m_rd_data = '0;
    if (rd_own_vld) m_rd_data[int'(rd_own_idx)*DW +: DW] = s_rd_data;
  end

endmodule

// File: tb/tb_naive_bus_arbiter.sv
// Directed self-checking bench for naive_bus_arbiter with three masters;
// contention expectations follow NB_ARB_ROUND_ROBIN_EN.
module tb_naive_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      m_rd_req;
  logic [N*AW-1:0]   m_rd_addr;
  logic [N-1:0]      m_rd_gnt;
  logic [N*DW-1:0]   m_rd_data;
  logic [N-1:0]      m_wr_req;
  logic [N*AW-1:0]   m_wr_addr;
  logic [N*DW-1:0]   m_wr_data;
  logic [N*DW/8-1:0] m_wr_be;
  logic [N-1:0]      m_wr_gnt;
  logic              s_rd_req;
  logic [AW-1:0]     s_rd_addr;
  logic              s_rd_gnt;
  logic [DW-1:0]     s_rd_data;
  logic              s_wr_req;
  logic [AW-1:0]     s_wr_addr;
  logic [DW-1:0]     s_wr_data;
  logic [DW/8-1:0]   s_wr_be;
  logic              s_wr_gnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  naive_bus_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_gnt(m_rd_gnt), .m_rd_data(m_rd_data),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_be(m_wr_be),
    .m_wr_gnt(m_wr_gnt),
    .s_rd_req(s_rd_req), .s_rd_addr(s_rd_addr), .s_rd_gnt(s_rd_gnt), .s_rd_data(s_rd_data),
    .s_wr_req(s_wr_req), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data), .s_wr_be(s_wr_be),
    .s_wr_gnt(s_wr_gnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns just after a rising edge so inputs change and outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rd(input int i, input logic r, input logic [AW-1:0] a);
    m_rd_req[i] = r;
    m_rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wr(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    m_wr_req[i] = w;
    m_wr_addr[i*AW +: AW] = a;
    m_wr_data[i*DW +: DW] = d;
    m_wr_be[i*DW/8 +: DW/8] = be;
  endtask

  task automatic clear_inputs();
    m_rd_req = '0; m_rd_addr = '0; m_wr_req = '0; m_wr_addr = '0;
    m_wr_data = '0; m_wr_be = '0; s_rd_gnt = 1'b0; s_wr_gnt = 1'b0; s_rd_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [N-1:0] cont_exp [4];

  initial begin
`ifdef NB_ARB_ROUND_ROBIN_EN
    cont_exp[0] = 3'b001; cont_exp[1] = 3'b010; cont_exp[2] = 3'b001; cont_exp[3] = 3'b010;
`else
    cont_exp[0] = 3'b001; cont_exp[1] = 3'b001; cont_exp[2] = 3'b001; cont_exp[3] = 3'b001;
`endif
    clear_inputs();
    rst_n = 1'b0;
    #3;
    check("rst_rd_gnt", m_rd_gnt, 0);
    check("rst_wr_gnt", m_wr_gnt, 0);
    check("rst_rd_data", m_rd_data, 0);
    check("rst_s_req", {s_rd_req, s_wr_req}, 0);
    check("rst_s_bus", {s_rd_addr, s_wr_addr, s_wr_data, s_wr_be}, 0);
    do_reset();

    // Single master read
    set_rd(1, 1'b1, 32'h100); s_rd_gnt = 1'b1;
    #1;
    check("single_s_rd_req", s_rd_req, 1);
    check("single_s_rd_addr", s_rd_addr, 32'h100);
    check("single_rd_gnt", m_rd_gnt, 3'b010);
    tick();
    set_rd(1, 1'b0, 32'h0); s_rd_gnt = 1'b0; s_rd_data = 32'hDEADBEEF;
    #1;
    check("single_rd_data", m_rd_data, {32'h0, 32'hDEADBEEF, 32'h0});
    check("single_idle_s_rd_req", s_rd_req, 0);
    tick();
    #1;
    check("single_data_gone", m_rd_data, 0);

    // Contention, slave always grants
    do_reset();
    set_rd(0, 1'b1, 32'hA0); set_rd(1, 1'b1, 32'hA1); s_rd_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("contend_gnt%0d", c), m_rd_gnt, cont_exp[c]);
      tick();
    end

    // Lock: m1 owns while slave stalls, m0 joins
    do_reset();
    set_rd(1, 1'b1, 32'h1111); s_rd_gnt = 1'b0;
    #1;
    check("lock_c1_addr", s_rd_addr, 32'h1111);
    tick();
    set_rd(0, 1'b1, 32'h0000_0AAA);
    for (int c = 2; c <= 3; c++) begin
      #1;
      check($sformatf("lock_c%0d_addr", c), s_rd_addr, 32'h1111);
      check($sformatf("lock_c%0d_gnt", c), m_rd_gnt, 0);
      tick();
    end
    s_rd_gnt = 1'b1;
    #1;
    check("lock_c4_gnt", m_rd_gnt, 3'b010);
    tick();
    set_rd(1, 1'b0, 32'h0); s_rd_data = 32'h1111_D000;
    #1;
    check("lock_c5_addr", s_rd_addr, 32'h0AAA);
    check("lock_c5_gnt", m_rd_gnt, 3'b001);
    check("lock_c5_data", m_rd_data, {32'h0, 32'h1111_D000, 32'h0});

    // Back-to-back return: m0 granted at t (above), m1 at t+1
    tick();
    set_rd(0, 1'b0, 32'h0); set_rd(1, 1'b1, 32'h2222); s_rd_data = 32'hD0D0_0000;
    #1;
    check("b2b_t1_gnt", m_rd_gnt, 3'b010);
    check("b2b_t1_data", m_rd_data, {32'h0, 32'h0, 32'hD0D0_0000});
    tick();
    set_rd(1, 1'b0, 32'h0); s_rd_gnt = 1'b0; s_rd_data = 32'hD1D1_1111;
    #1;
    check("b2b_t2_data", m_rd_data, {32'h0, 32'hD1D1_1111, 32'h0});

    // Read and write from the same master
    do_reset();
    set_rd(2, 1'b1, 32'h200);
    set_wr(2, 1'b1, 32'h300, 32'hCAFE_0002, 4'b0011);
    s_rd_gnt = 1'b1; s_wr_gnt = 1'b1;
    #1;
    check("rw_first_req", {s_rd_req, s_wr_req}, 2'b10);
    check("rw_first_gnt", {m_rd_gnt, m_wr_gnt}, {3'b100, 3'b000});
    tick();
    set_rd(2, 1'b0, 32'h0);
    #1;
    check("rw_second_req", {s_rd_req, s_wr_req}, 2'b01);
    check("rw_second_bus", {s_wr_addr, s_wr_data, s_wr_be}, {32'h300, 32'hCAFE_0002, 4'b0011});
    check("rw_second_gnt", {m_rd_gnt, m_wr_gnt}, {3'b000, 3'b100});
    tick();
    set_wr(2, 1'b0, 32'h0, 32'h0, 4'b0);

    // Locked owner drops its request
    do_reset();
    set_rd(1, 1'b1, 32'h1234); s_rd_gnt = 1'b0;
    tick();
    set_rd(1, 1'b0, 32'h0); set_rd(0, 1'b1, 32'h5678); s_rd_gnt = 1'b1;
    #1;
    check("drop_locked_req", s_rd_req, 0);
    check("drop_locked_gnt", m_rd_gnt, 0);
    tick();
    #1;
    check("drop_after_gnt", m_rd_gnt, 3'b001);
    check("drop_after_addr", s_rd_addr, 32'h5678);

    // Reset the cycle after a grant
    do_reset();
    set_rd(0, 1'b1, 32'h40); s_rd_gnt = 1'b1;
    tick();
    set_rd(0, 1'b0, 32'h0); s_rd_gnt = 1'b0; s_rd_data = 32'h5555_AAAA;
    rst_n = 1'b0;
    #1;
    check("midrst_rd_data", m_rd_data, 0);
    tick();
    rst_n = 1'b1;
    set_rd(0, 1'b1, 32'h70); set_rd(1, 1'b1, 32'h71); s_rd_gnt = 1'b1;
    #1;
    check("midrst_ptr_gnt", m_rd_gnt, 3'b001);
    tick();
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/naive_bus_arbiter.md
# naive_bus_arbiter

Shares one naive_bus slave port between `N_MASTERS` requesters, e.g. core `instr_master`, core `data_master`, and a DMA/debug master, in front of a single-port RAM or peripheral. The request path is combinational. Read data is returned one cycle after grant to the master that won the read. Selection is round-robin or fixed-priority; a master whose request is presented but not yet granted keeps ownership until the slave grants it.

## Interface
Parameters:
- `N_MASTERS`, 2: number of requesters, 2..8
- `AW`, 32: address width
- `DW`, 32: data width; `DW/8` byte enables

Ports (per-master signals are flattened vectors, master i at slice i):
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `m_rd_req`  in  N_MASTERS  read request, held until `m_rd_gnt`
- `m_rd_addr`  in  N_MASTERS*AW  read address
- `m_rd_gnt`  out  N_MASTERS  read accepted this cycle
- `m_rd_data`  out  N_MASTERS*DW  read data, valid the cycle after `m_rd_gnt`
- `m_wr_req`  in  N_MASTERS  write request, held until `m_wr_gnt`
- `m_wr_addr`  in  N_MASTERS*AW  write address
- `m_wr_data`  in  N_MASTERS*DW  write data
- `m_wr_be`  in  N_MASTERS*DW/8  byte enables
- `m_wr_gnt`  out  N_MASTERS  write accepted this cycle
- `s_rd_req`, `s_rd_addr`, `s_wr_req`, `s_wr_addr`, `s_wr_data`, `s_wr_be`  out  to slave, widths as above
- `s_rd_gnt`, `s_wr_gnt`  in  1  slave acceptance
- `s_rd_data`  in  DW  slave read data, one cycle after `s_rd_gnt`

## Operation
- Registers:
  - `rr_ptr` holds the highest-priority index.
  - `lock_vld`/`lock_idx` hold the current owner of an unaccepted request.
  - `rd_own_vld`/`rd_own_idx` route read data.
- Candidate set: masters with `m_rd_req|m_wr_req`.
- Owner selection:
  - If `lock_vld`, the owner is `lock_idx`.
  - Otherwise the owner is the first candidate at or after `rr_ptr`, wrapping mod N_MASTERS.
- The owner's signals drive the `s_*` outputs. If the owner asserts both requests, only the read is forwarded this cycle; the write is forwarded after the read is granted.
- Non-owners see `m_*_gnt=0`. The owner's forwarded request gets `m_*_gnt = s_*_gnt`.
- With no candidates: `s_rd_req=s_wr_req=0`, and addresses and data are driven 0.
- Register updates on a clock edge:
  - A request forwarded but not granted sets `lock_vld=1`, `lock_idx=owner`.
  - Any grant clears `lock_vld` and sets `rr_ptr=(owner+1) mod N_MASTERS`.
- Read return:
  - On `s_rd_gnt`, `rd_own_vld<=1` and `rd_own_idx<=owner`; otherwise `rd_own_vld<=0`.
  - `m_rd_data[rd_own_idx] = s_rd_data` when `rd_own_vld`. All other slices are 0.
- Boundaries:
  - A master dropping its request while locked (protocol violation) clears the lock next cycle, with no grant.
  - `N_MASTERS` not a power of two: the pointer wraps explicitly at N_MASTERS-1.
- Reset: `rr_ptr=0`, `lock_vld=0`, `rd_own_vld=0`. All `m_*_gnt`, `m_rd_data` and `s_*` outputs read 0 while no request is present. Reset mid-transaction drops any pending read return.

## Timing
- Request to `s_*`, and `s_*_gnt` to `m_*_gnt`: 0 cycles (combinational).
- `m_rd_data`: 1 cycle after `m_rd_gnt`.
- Back-to-back reads from different masters in consecutive cycles are supported. `rd_own_idx` updates every granted cycle.
- Throughput: one accepted transaction per cycle. With all masters requesting continuously, each master is granted once per N_MASTERS accepted transactions (round-robin build).

## Configuration
- `NB_ARB_ROUND_ROBIN_EN` defined: round-robin selection as above.
- `NB_ARB_ROUND_ROBIN_EN` undefined: fixed priority, index 0 highest.
  - `rr_ptr` is not instantiated and is treated as 0.
  - Lock behaviour and read return are unchanged.

## Structure
- Package `naive_bus_arb_pkg` holds:
  - `NB_ARB_MAX_MASTERS=8`
  - the `idx_t` typedef (3-bit index)
  - the function `nb_wrap_inc(idx, n)`
- Sub-module `nb_rr_pick`: combinational, takes request vector and pointer, returns `found` and `idx`. Reused by any later interrupt or DMA arbiter.

## Test plan
- **Single master:** m1 read 0x100; `s_rd_gnt=1` and `s_rd_data=0xDEADBEEF` next cycle → `m_rd_gnt[1]=1`; next cycle `m_rd_data[1]=0xDEADBEEF`, `m_rd_data[0]=0`.
- **Contention (round-robin build):** m0 and m1 both request continuously, slave always grants, `rr_ptr=0` → grants go 0,1,0,1.
- **Contention (fixed-priority build):** same stimulus → master 0 always wins.
- **Lock:** m1 owns and `s_rd_gnt` held 0 for 3 cycles while m0 also requests → `s_rd_addr` stays m1's address for all 3 cycles; m1 is granted on cycle 4; m0 is owner on cycle 5.
- **Back-to-back return:** read m0 granted in cycle t, read m1 granted in t+1 → data at t+1 goes to m0, data at t+2 goes to m1, with no overlap.
- **Read+write same master:** m2 asserts both → read forwarded first; write forwarded the cycle after `s_rd_gnt` with `wr_be=4'b0011` intact.
- **Reset mid-read:** assert `rst_n=0` the cycle after a grant → `m_rd_data` all 0, `rr_ptr=0`, lock cleared.
